// File: rtl/regfile_mp_if.sv
// Register-file port bundle: decode/writeback side drives writes, reads and busy marks.
// The register file returns registered read data and busy flags.
interface regfile_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NWR   = 2,
   parameter int NRD   = 4
);
   localparam int AW = $clog2(NREGS);

   logic [NWR*AW-1:0]   rd_addr_i;
   logic [NWR*XLEN-1:0] rd_data_i;
   logic [NWR-1:0]      rd_write_i;
   logic [NRD*AW-1:0]   rs_addr_i;
   logic [NRD-1:0]      rs_en_i;
   logic [NRD*XLEN-1:0] rs_data_o;
   logic [NRD-1:0]      rs_busy_o;
   logic [NWR*AW-1:0]   busy_set_addr_i;
   logic [NWR-1:0]      busy_set_i;

   modport master (
      output rd_addr_i, rd_data_i, rd_write_i, rs_addr_i, rs_en_i,
             busy_set_addr_i, busy_set_i,
      input  rs_data_o, rs_busy_o
   );

   modport slave (
      input  rd_addr_i, rd_data_i, rd_write_i, rs_addr_i, rs_en_i,
             busy_set_addr_i, busy_set_i,
      output rs_data_o, rs_busy_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with write-to-read bypass and per-register busy scoreboard.
// Latency: reads and busy flags registered, 1 cycle; same-cycle writes/marks are bypassed.
// Backpressure: none; rs_en_i low holds that port's registered outputs.
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NWR   = 2,
   parameter int NRD   = 4
) (
   input  logic          clock_i,
   input  logic          reset_i,
   regfile_mp_if.slave   rf
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]     regs     [NREGS];
   logic [XLEN-1:0]     regs_nxt [NREGS];
   logic [NREGS-1:0]    busy;
   logic [NREGS-1:0]    busy_nxt;
   logic [NRD*XLEN-1:0] rs_data_q;
   logic [NRD-1:0]      rs_busy_q;

   // Ascending port order lets the youngest lane overwrite older lanes; marks
   // are applied after clears so a new producer survives an old one retiring.
   always_comb begin
      for (int n = 0; n < NREGS; n++) begin
         regs_nxt[n] = regs[n];
      end
      busy_nxt = busy;
      for (int p = 0; p < NWR; p++) begin
         if (rf.rd_write_i[p]) begin
            regs_nxt[rf.rd_addr_i[p*AW +: AW]] = rf.rd_data_i[p*XLEN +: XLEN];
            busy_nxt[rf.rd_addr_i[p*AW +: AW]] = 1'b0;
         end
      end
      for (int p = 0; p < NWR; p++) begin
         if (rf.busy_set_i[p]) begin
            busy_nxt[rf.busy_set_addr_i[p*AW +: AW]] = 1'b1;
         end
      end
      regs_nxt[0] = '0;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int n = 0; n < NREGS; n++) begin
            regs[n] <= '0;
         end
         busy      <= '0;
         rs_data_q <= '0;
         rs_busy_q <= '0;
      end else begin
         for (int n = 0; n < NREGS; n++) begin
            regs[n] <= regs_nxt[n];
         end
         busy <= busy_nxt;
         for (int r = 0; r < NRD; r++) begin
            if (rf.rs_en_i[r]) begin
               rs_data_q[r*XLEN +: XLEN] <= regs_nxt[rf.rs_addr_i[r*AW +: AW]];
               rs_busy_q[r]              <= busy_nxt[rf.rs_addr_i[r*AW +: AW]];
            end
         end
      end
   end

   assign rf.rs_data_o = rs_data_q;
   assign rf.rs_busy_o = rs_busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios with literal expectations, then randomized
// traffic, all outputs compared every cycle against a behavioural register-file model.
module tb_regfile_mp;
   localparam int XLEN  = 64;
   localparam int NREGS = 16;
   localparam int NWR   = 3;
   localparam int NRD   = 6;
   localparam int AW    = $clog2(NREGS);

   logic clock_i = 1'b0;
   logic reset_i = 1'b1;

   regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .NRD(NRD)) rf ();

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .NRD(NRD)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .rf      (rf.slave)
   );

   always #5 clock_i = ~clock_i;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   // Architectural model: contents and busy flags plus what each read port should show.
   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];
   logic [XLEN-1:0] exp_data [NRD];
   bit              exp_busy [NRD];

   initial begin
      for (int n = 0; n < NREGS; n++) begin
         m_regs[n] = '0;
         m_busy[n] = 1'b0;
      end
      for (int r = 0; r < NRD; r++) begin
         exp_data[r] = '0;
         exp_busy[r] = 1'b0;
      end
   end

   always @(posedge clock_i) begin
      logic [XLEN-1:0] nr [NREGS];
      bit              nb [NREGS];
      int              a;
      if (reset_i) begin
         for (int n = 0; n < NREGS; n++) begin
            m_regs[n] = '0;
            m_busy[n] = 1'b0;
         end
         for (int r = 0; r < NRD; r++) begin
            exp_data[r] = '0;
            exp_busy[r] = 1'b0;
         end
      end else begin
         nr = m_regs;
         nb = m_busy;
         // Later lanes are younger: applying writes in port order leaves the youngest.
         for (int p = 0; p < NWR; p++) begin
            a = int'(rf.rd_addr_i[p*AW +: AW]);
            if (rf.rd_write_i[p] && a != 0) begin
               nr[a] = rf.rd_data_i[p*XLEN +: XLEN];
               nb[a] = 1'b0;
            end
         end
         for (int p = 0; p < NWR; p++) begin
            a = int'(rf.busy_set_addr_i[p*AW +: AW]);
            if (rf.busy_set_i[p] && a != 0) nb[a] = 1'b1;
         end
         for (int r = 0; r < NRD; r++) begin
            a = int'(rf.rs_addr_i[r*AW +: AW]);
            if (rf.rs_en_i[r]) begin
               exp_data[r] = (a == 0) ? '0 : nr[a];
               exp_busy[r] = (a == 0) ? 1'b0 : nb[a];
            end
         end
         m_regs = nr;
         m_busy = nb;
      end
   end

   always @(negedge clock_i) begin
      if (chk_en) begin
         for (int r = 0; r < NRD; r++) begin
            vectors++;
            if (rf.rs_data_o[r*XLEN +: XLEN] !== exp_data[r]) begin
               miscompares++;
               $display("FAIL rs_data[%0d] t=%0t: got %h expected %h", r, $time,
                        rf.rs_data_o[r*XLEN +: XLEN], exp_data[r]);
            end
            vectors++;
            if (rf.rs_busy_o[r] !== exp_busy[r]) begin
               miscompares++;
               $display("FAIL rs_busy[%0d] t=%0t: got %b expected %b", r, $time,
                        rf.rs_busy_o[r], exp_busy[r]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clr();
      rf.rd_addr_i       = '0;
      rf.rd_data_i       = '0;
      rf.rd_write_i      = '0;
      rf.rs_addr_i       = '0;
      rf.rs_en_i         = '0;
      rf.busy_set_addr_i = '0;
      rf.busy_set_i      = '0;
   endtask

   task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
      rf.rd_addr_i[p*AW +: AW]   = AW'(a);
      rf.rd_data_i[p*XLEN +: XLEN] = d;
      rf.rd_write_i[p]           = 1'b1;
   endtask

   task automatic rd(input int r, input int a);
      rf.rs_addr_i[r*AW +: AW] = AW'(a);
      rf.rs_en_i[r]            = 1'b1;
   endtask

   task automatic setb(input int p, input int a);
      rf.busy_set_addr_i[p*AW +: AW] = AW'(a);
      rf.busy_set_i[p]               = 1'b1;
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   function automatic logic [XLEN-1:0] dout(input int r);
      return rf.rs_data_o[r*XLEN +: XLEN];
   endfunction

   initial begin
      clr();
      // Writes during reset must be discarded.
      reset_i = 1'b1;
      wr(0, 5, 64'hDEADBEEF);
      tick();
      chk_en = 1'b1;
      tick();
      reset_i = 1'b0;
      clr();
      for (int r = 0; r < NRD; r++) rd(r, 5);
      tick();
      for (int r = 0; r < NRD; r++) begin
         check($sformatf("reset_x5_data[%0d]", r), dout(r), 64'h0);
         check($sformatf("reset_x5_busy[%0d]", r), {63'b0, rf.rs_busy_o[r]}, 64'h0);
      end

      clr(); wr(0, 3, 64'h12345678); tick();
      clr(); rd(2, 3); tick();
      check("read_x3", dout(2), 64'h12345678);
      clr(); wr(0, 0, 64'hFFFFFFFF); rd(1, 0); tick();
      check("read_x0", dout(1), 64'h0);

      clr(); wr(0, 7, 64'hAAAA0000); wr(1, 7, 64'h0000BBBB); rd(0, 7); tick();
      check("bypass_conflict_x7", dout(0), 64'h0000BBBB);
      clr(); rd(0, 7); tick();
      check("stored_x7", dout(0), 64'h0000BBBB);

      clr(); wr(0, 4, 64'h11); tick();
      clr(); rd(3, 4); tick();
      check("hold_first", dout(3), 64'h11);
      clr(); wr(0, 4, 64'h22); rf.rs_addr_i[3*AW +: AW] = AW'(4); tick();
      check("hold_stays", dout(3), 64'h11);
      clr(); rd(3, 4); tick();
      check("hold_release", dout(3), 64'h22);

      clr(); setb(0, 9); rd(4, 9); tick();
      check("busy_set_x9", {63'b0, rf.rs_busy_o[4]}, 64'h1);
      clr(); wr(1, 9, 64'h5); setb(0, 9); rd(4, 9); tick();
      check("busy_set_beats_clear", {63'b0, rf.rs_busy_o[4]}, 64'h1);
      clr(); wr(0, 9, 64'h6); rd(4, 9); tick();
      check("busy_cleared", {63'b0, rf.rs_busy_o[4]}, 64'h0);
      clr(); setb(0, 0); rd(4, 0); tick();
      check("busy_x0", {63'b0, rf.rs_busy_o[4]}, 64'h0);

      for (int i = 0; i < 10000; i++) begin
         clr();
         reset_i = ($urandom_range(0, 499) == 0);
         for (int p = 0; p < NWR; p++) begin
            if ($urandom_range(0, 1) == 1) wr(p, $urandom_range(0, NREGS-1), {$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) setb(p, $urandom_range(0, NREGS-1));
         end
         for (int r = 0; r < NRD; r++) begin
            rf.rs_addr_i[r*AW +: AW] = AW'($urandom_range(0, NREGS-1));
            rf.rs_en_i[r]            = ($urandom_range(0, 3) != 0);
         end
         tick();
      end
      reset_i = 1'b0;
      clr();
      tick();
      @(negedge clock_i);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-ported integer register file for the dual-issue core, replacing the fixed two-write/four-read file. It provides NWR write ports and NRD registered read ports, with write-to-read bypass and deterministic same-address write arbitration. A per-register busy scoreboard lets decode detect operands still pending from in-flight instructions. It sits between decode (reads, busy set) and writeback (writes, busy clear).

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS)
- NWR, 2, write ports; port 0 = lane A (older), higher index = younger lane
- NRD, 4, read ports; port 2k/2k+1 = rs1/rs2 of lane k
- clock_i  in  1  core clock, all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- rd_addr_i  in  NWR*AW  write addresses, port p at [p*AW +: AW]
- rd_data_i  in  NWR*XLEN  write data, port p at [p*XLEN +: XLEN]
- rd_write_i  in  NWR  write enable per port
- rs_addr_i  in  NRD*AW  read addresses, port r at [r*AW +: AW]
- rs_en_i  in  NRD  read enable per port; 0 = hold previous output
- rs_data_o  out  NRD*XLEN  registered read data
- rs_busy_o  out  NRD  registered busy flag of the addressed register
- busy_set_addr_i  in  NWR*AW  destination being issued, per lane
- busy_set_i  in  NWR  mark busy_set_addr as pending

## Operation
- Storage: NREGS × XLEN flops plus NREGS busy bits. Register 0 is hardwired: never written, always reads 0, never busy (set requests to 0 ignored).
- Write: on posedge, for each port p with rd_write_i[p]=1 and rd_addr≠0, register ← rd_data. Same address on several ports in one cycle: the highest-index port wins.
- Read: on posedge, for each r with rs_en_i[r]=1, rs_data_o[r] ← value of rs_addr after this cycle's writes (bypass: if any enabled write targets rs_addr≠0, return the winning write data, else stored value). rs_en_i[r]=0 holds rs_data_o[r] and rs_busy_o[r].
- Busy scoreboard, per register n≠0, next state:
  - set if any busy_set_i[p] with busy_set_addr=n;
  - else cleared if any rd_write_i[p] with rd_addr=n;
  - else unchanged. Set wins over clear in the same cycle (new producer issued as old one retires).
- rs_busy_o[r] ← next-state busy bit of rs_addr (same post-update view as data); 0 for address 0.
- Reset (reset_i=1 at posedge): all registers 0, all busy bits 0, rs_data_o=0, rs_busy_o=0. Reset overrides every write, set and read in that cycle.
- Out-of-range handling not needed: NREGS is a power of two.

## Timing
- Read latency 1 cycle: address presented before edge k → data/busy valid after edge k, stable until next enabled edge.
- Write visible to same-cycle read (bypass) and to all later reads.
- Busy set at edge k seen by reads at edge k and later; clear at edge k likewise.
- Reset mid-operation: pending writes and busy marks in the reset cycle are discarded; first normal edge is the one after reset_i falls.
- No combinational path from inputs to outputs.
- Write-enable vs. address-0: rd_write_i to x0 does not clear or set anything and does not bypass.

## Test plan
- Reset: hold reset_i 2 cycles with writes x5←0xDEADBEEF on port 0 → after release, read x5 on all ports = 0x00000000, rs_busy_o = 0.
- Write/read: port 0 writes x3←0x12345678 at edge k, read x3 on port 2 at edge k+1 → 0x12345678; read x0 after writing x0←0xFFFFFFFF → 0.
- Bypass and conflict: at one edge, port 0 writes x7←0xAAAA0000, port 1 writes x7←0x0000BBBB, port 0 reads x7 → 0x0000BBBB same edge; next-cycle read of x7 → 0x0000BBBB.
- Hold: read x4=0x11 with rs_en=1, then write x4←0x22 with rs_en=0 → rs_data_o stays 0x11; raise rs_en → 0x22.
- Scoreboard: busy_set x9 at edge k → rs_busy for x9 = 1 at edge k; write x9 and busy_set x9 same edge → stays 1; write x9 alone → 0; busy_set x0 → 0.
- Randomised NWR=3, NRD=6, NREGS=16, XLEN=64 against reference model for 10k cycles → zero mismatches.
